cpu_ctrl: RTL

Multi-cycle control FSM for the 19-bit CPU. It sequences fetch, decode, execute, memory and writeback around the instruction decoder. It consumes the decoder's opcode and type flags, performs the instruction-memory, data-memory and coprocessor handshakes, and drives the PC, IR, register-file and writeback-select enables. It also counts retired instructions and traps stalled handshakes into an error state.

---
 rtl/pkgs.sv | 47 ++++
 rtl/ctrl_wdog.sv | 34 +++
 rtl/cpu_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/pkgs.sv
// Shared CPU package: opcode map, control-FSM state encoding and the PC / writeback select
// codes used by the multi-cycle controller.
package pkgs;

  // Opcode map of the 19-bit CPU (4-bit opcode field).
  localparam logic [3:0] R_TYPE   = 4'h0;
  localparam logic [3:0] I_TYPE_0 = 4'h1;  // ALU immediate
  localparam logic [3:0] I_TYPE_1 = 4'h2;  // load
  localparam logic [3:0] S_TYPE   = 4'h3;
  localparam logic [3:0] B_TYPE   = 4'h4;
  localparam logic [3:0] U_TYPE   = 4'h5;
  localparam logic [3:0] J_TYPE   = 4'h6;
  localparam logic [3:0] C_TYPE   = 4'h7;

  // funct3 of a C-type instruction that stops the core.
  localparam logic [2:0] HALT_FUNCT3 = 3'b111;

  // Width of the handshake watchdog counter.
  localparam int unsigned WDOG_W = 8;

  // HALT and ERR share the visible encoding 7; bit 3 only distinguishes them internally.
  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StExec   = 4'd3,
    StMem    = 4'd4,
    StCop    = 4'd5,
    StWb     = 4'd6,
    StHalt   = 4'd7,
    StErr    = 4'd15
  } ctrl_state_e;

  typedef enum logic [1:0] {
    PcInc    = 2'd0,
    PcBranch = 2'd1,
    PcJump   = 2'd2
  } pc_sel_e;

  typedef enum logic [1:0] {
    WbAlu  = 2'd0,
    WbMem  = 2'd1,
    WbLink = 2'd2,
    WbCop  = 2'd3
  } wb_sel_e;

endpackage

// File: rtl/ctrl_wdog.sv
// Handshake watchdog: counts cycles spent waiting on a handshake and flags expiry.
// Ports:
//   clk_i, rst_ni  clock, synchronous active-low reset
//   clr_i          clear the count (state change)
//   en_i           count this cycle (waiting state)
//   expired_o      this waiting cycle is the TIMEOUT-th one
module ctrl_wdog
  import pkgs::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [WDOG_W-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (en_i) begin
      r_cnt <= r_cnt + WDOG_W'(1);
    end
  end

  // The count starts at 0 in the first waiting cycle, so TIMEOUT-1 marks the last allowed one.
  assign expired_o = en_i && (r_cnt == WDOG_W'(TIMEOUT - 1));

endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle control FSM: fetch, decode, execute, memory, coprocessor and writeback
// sequencing with imem/dmem/coprocessor handshakes, retired-instruction counter and a
// handshake watchdog that traps stalls into ERR.
// Ports:
//   run_i                        start request (IDLE only)
//   op_i, funct3_i, *_type_i     decoded instruction fields and type flags
//   branch_taken_i               ALU branch result (EXEC)
//   imem_*/dmem_*/cop_*          handshakes
//   ir_we_o, pc_we_o, pc_sel_o   IR / PC control
//   rf_we_o, wb_sel_o            register-file writeback control
//   busy_o, halted_o, err_o      status; state_o current state; retired_o retire count
module cpu_ctrl
  import pkgs::*;
#(
  parameter int unsigned RET_CNT_W = 16,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 run_i,
  input  logic [3:0]           op_i,
  input  logic [2:0]           funct3_i,
  input  logic                 r_type_i,
  input  logic                 i_type_i,
  input  logic                 s_type_i,
  input  logic                 b_type_i,
  input  logic                 u_type_i,
  input  logic                 j_type_i,
  input  logic                 c_type_i,
  input  logic                 branch_taken_i,
  output logic                 imem_req_o,
  input  logic                 imem_rdy_i,
  output logic                 dmem_req_o,
  output logic                 dmem_we_o,
  input  logic                 dmem_rdy_i,
  output logic                 cop_start_o,
  input  logic                 cop_done_i,
  output logic                 ir_we_o,
  output logic                 pc_we_o,
  output logic [1:0]           pc_sel_o,
  output logic                 rf_we_o,
  output logic [1:0]           wb_sel_o,
  output logic                 busy_o,
  output logic                 halted_o,
  output logic                 err_o,
  output logic [2:0]           state_o,
  output logic [RET_CNT_W-1:0] retired_o
);

  ctrl_state_e         r_state, w_state_next;
  logic [RET_CNT_W-1:0] r_retired;
  logic                w_retire;
  logic                w_expired;
  logic                w_wait;
  pc_sel_e             w_pc_sel;
  wb_sel_e             w_wb_sel;

  logic w_load, w_store, w_halt, w_any_type;

  assign w_load     = (op_i == I_TYPE_1);
  assign w_store    = (op_i == S_TYPE);
  assign w_halt     = (op_i == C_TYPE) && (funct3_i == HALT_FUNCT3);
  assign w_any_type = |{r_type_i, i_type_i, s_type_i, b_type_i, u_type_i, j_type_i, c_type_i};

  assign w_wait = (r_state == StFetch) || (r_state == StMem) || (r_state == StCop);

  ctrl_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (w_state_next != r_state),
    .en_i      (w_wait),
    .expired_o (w_expired)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state   <= StIdle;
      r_retired <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_retire) r_retired <= r_retired + RET_CNT_W'(1);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_retire     = 1'b0;
    w_pc_sel     = PcInc;
    w_wb_sel     = WbAlu;
    imem_req_o   = 1'b0;
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    cop_start_o  = 1'b0;
    ir_we_o      = 1'b0;
    pc_we_o      = 1'b0;
    rf_we_o      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (run_i) w_state_next = StFetch;
      end
      StFetch: begin
        imem_req_o = 1'b1;
        if (imem_rdy_i) begin
          ir_we_o      = 1'b1;
          w_state_next = StDecode;
        end else if (w_expired) begin
          w_state_next = StErr;
        end
      end
      StDecode: w_state_next = StExec;
      StExec: begin
        if (!w_any_type) begin
          w_state_next = StErr;
        end else if (w_halt) begin
          w_state_next = StHalt;
        end else if (b_type_i) begin
          pc_we_o      = 1'b1;
          w_pc_sel     = branch_taken_i ? PcBranch : PcInc;
          w_retire     = 1'b1;
          w_state_next = StFetch;
        end else if (w_load || w_store) begin
          w_state_next = StMem;
        end else if (c_type_i) begin
          cop_start_o  = 1'b1;
          w_state_next = StCop;
        end else begin
          w_state_next = StWb;
        end
      end
      StMem: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = w_store;
        if (dmem_rdy_i) begin
          if (w_store) begin
            pc_we_o      = 1'b1;
            w_retire     = 1'b1;
            w_state_next = StFetch;
          end else begin
            w_state_next = StWb;
          end
        end else if (w_expired) begin
          w_state_next = StErr;
        end
      end
      StCop: begin
        if (cop_done_i) begin
          w_state_next = StWb;
        end else if (w_expired) begin
          w_state_next = StErr;
        end
      end
      StWb: begin
        rf_we_o      = 1'b1;
        pc_we_o      = 1'b1;
        w_retire     = 1'b1;
        w_state_next = StFetch;
        if (w_load)        w_wb_sel = WbMem;
        else if (c_type_i) w_wb_sel = WbCop;
        else if (j_type_i) w_wb_sel = WbLink;
        if (j_type_i) w_pc_sel = PcJump;
      end
      StHalt, StErr: ;
      default: w_state_next = StErr;
    endcase
  end

  assign pc_sel_o  = w_pc_sel;
  assign wb_sel_o  = w_wb_sel;
  assign busy_o    = (r_state != StIdle);
  assign halted_o  = (r_state == StHalt);
  assign err_o     = (r_state == StErr);
  assign state_o   = r_state[2:0];
  assign retired_o = r_retired;

endmodule
